// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cooking timer.
// BCD digit type, display limits and the timer state encoding.
package microwave_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX       = 4'd9;
  localparam bcd_t SEC_TENS_WRAP = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
// Holds its count while disabled; clr and rst return it to zero.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// MM:SS cooking-time countdown feeding the magnetron control block.
// Keypad shift-in entry, BCD borrow-chain decrement, sticky timer_done.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       mag,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done
);

  state_t state, state_nx;

  bcd_t mt, mo, st, so;
  bcd_t mt_d, mo_d, st_d, so_d;

  logic nz;
  logic dec_zero;
  logic accept;
  logic tick;
  logic pre_en;
  logic pre_clr;

  assign nz     = |{mt, mo, st, so};
  assign accept = digit_valid && !mag && (digit <= BCD_MAX);

  // The prescaler also runs on the IDLE->RUN edge so the first
  // decrement lands exactly TICKS_PER_SEC mag-high cycles later.
  assign pre_en  = clearn && mag && nz && (state != DONE);
  assign pre_clr = !clearn ||
                   ((state_nx == DONE) && (state != DONE));

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .en  (pre_en),
    .tick(tick)
  );

  always_comb begin
    mt_d = mt;
    mo_d = mo;
    st_d = st;
    so_d = so;
    if (so != '0) begin
      so_d = so - 4'd1;
    end else if (st != '0) begin
      so_d = BCD_MAX;
      st_d = st - 4'd1;
    end else begin
      so_d = BCD_MAX;
      st_d = SEC_TENS_WRAP;
      if (mo != '0) begin
        mo_d = mo - 4'd1;
      end else begin
        mo_d = BCD_MAX;
        mt_d = mt - 4'd1;
      end
    end
  end

  assign dec_zero = ~|{mt_d, mo_d, st_d, so_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!clearn) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (!mag) begin
            state_nx = IDLE;
          end else if (!nz || (tick && dec_zero)) begin
            state_nx = DONE;
          end else begin
            state_nx = RUN;
          end
        end
        DONE: begin
          if (accept) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    timer_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || !clearn) begin
      mt <= '0;
      mo <= '0;
      st <= '0;
      so <= '0;
    end else if (accept) begin
      mt <= mo;
      mo <= st;
      st <= so;
      so <= digit;
    end else if (tick) begin
      mt <= mt_d;
      mo <= mo_d;
      st <= st_d;
      so <= so_d;
    end
  end

  assign min_tens = mt;
  assign min_ones = mo;
  assign sec_tens = st;
  assign sec_ones = so;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICKS_PER_SEC = 4.
// Hand-computed display/done expectations after each clock step.
module tb_microwave_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clearn;
  logic       mag;
  logic [3:0] digit;
  logic       digit_valid;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  microwave_timer #(
    .TICKS_PER_SEC(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clearn     (clearn),
    .mag        (mag),
    .digit      (digit),
    .digit_valid(digit_valid),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic clr();
    clearn = 1'b0;
    step();
    clearn = 1'b1;
  endtask

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    rst = 1'b1;
    clearn = 1'b1;
    mag = 1'b0;
    digit = 4'd0;
    digit_valid = 1'b0;
    step(2);
    rst = 1'b0;
    step();
    chk("rst_disp", disp(), 16'h0000);
    chk("rst_done", timer_done, 1'b0);
    step(20);
    chk("idle_disp", disp(), 16'h0000);
    chk("idle_done", timer_done, 1'b0);

    key(4'd1);
    chk("entry1", disp(), 16'h0001);
    key(4'd0);
    key(4'd5);
    chk("entry105", disp(), 16'h0105);
    key(4'hC);
    chk("entry_bad", disp(), 16'h0105);
    mag = 1'b1;
    key(4'd7);
    chk("entry_mag", disp(), 16'h0105);
    mag = 1'b0;
    step();

    clr();
    chk("clr_disp", disp(), 16'h0000);
    key(4'd0);
    key(4'd3);
    chk("load3", disp(), 16'h0003);
    mag = 1'b1;
    step(4);
    chk("cd_4", disp(), 16'h0002);
    step(4);
    chk("cd_8", disp(), 16'h0001);
    step(3);
    chk("cd_11_done", timer_done, 1'b0);
    step();
    chk("cd_12", disp(), 16'h0000);
    chk("cd_12_done", timer_done, 1'b1);
    step(10);
    chk("sticky_done", timer_done, 1'b1);
    chk("no_underflow", disp(), 16'h0000);

    mag = 1'b0;
    step();
    chk("sticky_mag0", timer_done, 1'b1);
    key(4'd0);
    chk("key_clr_done", timer_done, 1'b0);
    key(4'd1);
    key(4'd0);
    key(4'd0);
    chk("load100", disp(), 16'h0100);
    mag = 1'b1;
    step(4);
    chk("borrow_100", disp(), 16'h0059);
    mag = 1'b0;
    clr();
    key(4'd1);
    key(4'd0);
    key(4'd0);
    key(4'd0);
    mag = 1'b1;
    step(4);
    chk("borrow_1000", disp(), 16'h0959);
    mag = 1'b0;
    clr();
    key(4'd9);
    key(4'd0);
    mag = 1'b1;
    step(4);
    chk("borrow_90", disp(), 16'h0089);

    mag = 1'b0;
    clr();
    key(4'd5);
    mag = 1'b1;
    step(6);
    chk("pause_run6", disp(), 16'h0004);
    mag = 1'b0;
    step(10);
    chk("pause_hold", disp(), 16'h0004);
    mag = 1'b1;
    step();
    chk("resume_1", disp(), 16'h0004);
    step();
    chk("resume_2", disp(), 16'h0003);

    mag = 1'b0;
    clr();
    key(4'd7);
    mag = 1'b1;
    step(2);
    clearn = 1'b0;
    step();
    chk("clrn_disp", disp(), 16'h0000);
    chk("clrn_done", timer_done, 1'b0);
    clearn = 1'b1;
    step();
    chk("zero_mag_done", timer_done, 1'b1);

    mag = 1'b0;
    key(4'd9);
    chk("load9", disp(), 16'h0009);
    mag = 1'b1;
    step(2);
    rst = 1'b1;
    step();
    chk("rst_mid_disp", disp(), 16'h0000);
    chk("rst_mid_done", timer_done, 1'b0);
    rst = 1'b0;
    mag = 1'b0;
    key(4'd2);
    mag = 1'b1;
    step(4);
    chk("post_rst_tick", disp(), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
